sub_bytes_iter: RTL and testbench

- Sequential, parametrised SubBytes/InvSubBytes engine for the 128-bit AES state.
- Uses LANES S-box instances, folded over 16/LANES cycles, so area and throughput can be traded per build.
- Adds a per-block encrypt/decrypt mode, a valid/ready handshake on both sides, and a synchronous flush.
- Sits between AddRoundKey and ShiftRows in iterative round datapaths where a 16-S-box SubBytes is too large.

---
 rtl/sub_bytes_iter.sv | 192 +++++++++++++++++++
 tb/tb_sub_bytes_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: folded SubBytes / InvSubBytes engine for a 128-bit AES state.
// LANES S-box lanes are applied per cycle, so a block takes N = 16/LANES
// substitution cycles between accept and result.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous abort back to IDLE
//   in_valid/in_ready   input handshake; data_in and inv_in captured at accept
//   data_in[127:0]      state, byte 0 = [127:120] ... byte 15 = [7:0]
//   inv_in              0 = forward S-box, 1 = inverse S-box
//   out_valid/out_ready output handshake; data_out held stable until accepted
//   data_out[127:0]     substituted state, same byte order as data_in
//   busy                high while a block is in flight or waiting in DONE
//
// Also contains the S_BOX / INV_S_BOX lane modules and their shared
// GF(2^8) inverter gf_inv8.

module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic         inv_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);
   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
         $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [127:0]  work;
   logic          mode;

   logic [3:0]    lane_idx [LANES];
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    fwd_out  [LANES];
   logic [7:0]    inv_out  [LANES];
   logic [127:0]  work_next;

   // Byte-group mux: lane l works on byte cnt*LANES+l of the work register.
   // With LANES=16 cnt stays 0 and this collapses to a straight pass-through.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l] = 4'(int'(cnt) * LANES + l);
         lane_in[l]  = work[8*(15 - int'(lane_idx[l])) +: 8];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      S_BOX     u_fwd (.box_sel(lane_in[l]), .box_out(fwd_out[l]));
      INV_S_BOX u_inv (.box_sel(lane_in[l]), .box_out(inv_out[l]));
   end

   // Write the substituted lane bytes back into their slots; all other
   // bytes of the work register hold their value.
   always_comb begin
      work_next = work;
      for (int l = 0; l < LANES; l++) begin
         work_next[8*(15 - int'(lane_idx[l])) +: 8] = mode ? inv_out[l] : fwd_out[l];
      end
   end

   // Control FSM. Flush outranks both handshakes, so an in_valid arriving
   // in the same cycle as flush is dropped. out_valid is registered and is
   // set on the last substitution edge so it rises together with DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         work      <= '0;
         mode      <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work  <= data_in;
                  mode  <= inv_in;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               work <= work_next;
               if (int'(cnt) == N - 1) begin
                  cnt       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Remaining outputs are pure state decodes, never the input handshakes.
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign data_out = work;

endmodule

// gf_inv8: multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1,
// computed as a^254 by repeated squaring; 0 maps to 0.
// Ports: a = operand, y = inverse.
module gf_inv8 (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Accumulate a^2 * a^4 * ... * a^128 = a^254.
   always_comb begin
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      y = acc;
   end
endmodule

// S_BOX: forward AES S-box, GF inverse followed by the affine transform.
// Ports: box_sel = input byte, box_out = substituted byte.
module S_BOX (
   input  logic [7:0] box_sel,
   output logic [7:0] box_out
);
   logic [7:0] b;

   gf_inv8 u_inv (.a(box_sel), .y(b));

   assign box_out = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// INV_S_BOX: inverse AES S-box, inverse affine transform then GF inverse.
// Ports: box_sel = input byte, box_out = substituted byte.
module INV_S_BOX (
   input  logic [7:0] box_sel,
   output logic [7:0] box_out
);
   logic [7:0] s;
   logic [7:0] b;

   assign b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
   assign s = box_sel;

   gf_inv8 u_inv (.a(b), .y(box_out));
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: self-checking bench for sub_bytes_iter. The main DUT
// uses LANES=4; two extra instances (LANES=1 and LANES=16) share its inputs
// and are checked for latency and data on a dedicated block. Expected data
// comes from S-box tables the bench builds itself from GF(2^8) arithmetic.

module tb_sub_bytes_iter;

   localparam int N_MAIN = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic [127:0] data_in;
   logic         inv_in;
   logic         out_ready;

   logic         in_ready, out_valid, busy;
   logic [127:0] data_out;
   logic         in_ready_1, out_valid_1, busy_1;
   logic [127:0] data_out_1;
   logic         in_ready_16, out_valid_16, busy_16;
   logic [127:0] data_out_16;

   int compared;
   int mismatched;

   logic [7:0] sboxTbl [256];
   logic [7:0] invTbl  [256];

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   sub_bytes_iter #(.LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .inv_in(inv_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .busy(busy)
   );

   sub_bytes_iter #(.LANES(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
      .data_in(data_in), .inv_in(inv_in), .out_valid(out_valid_1), .out_ready(out_ready),
      .data_out(data_out_1), .busy(busy_1)
   );

   sub_bytes_iter #(.LANES(16)) dut_l16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
      .data_in(data_in), .inv_in(inv_in), .out_valid(out_valid_16), .out_ready(out_ready),
      .data_out(data_out_16), .busy(busy_16)
   );

   // Plain shift-and-add GF(2^8) multiply used only to build the tables.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p;
      int aa;
      int bb;
      p  = 0;
      aa = int'(a);
      bb = int'(b);
      while (bb != 0) begin
         if ((bb & 1) != 0) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
         bb = bb >> 1;
      end
      return 8'(p);
   endfunction

   // Forward table: brute-force inverse search plus the bitwise affine rule;
   // the inverse table is simply the forward table read backwards.
   task automatic buildTables();
      int         invVal;
      logic [7:0] b;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         invVal = 0;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) invVal = y;
         end
         b = 8'(invVal);
         for (int i = 0; i < 8; i++) begin
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
         end
         sboxTbl[x] = s;
         invTbl[s]  = 8'(x);
      end
   endtask

   // Reference model: every byte independently through the chosen table.
   function automatic logic [127:0] refSub(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = inv ? invTbl[d[8*i +: 8]] : sboxTbl[d[8*i +: 8]];
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for in_ready, present one block for a single cycle, then
   // scramble data_in/inv_in so later changes are seen to have no effect.
   task automatic applyStimulus(input logic [127:0] d, input logic inv);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      while (!in_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("in_ready_wait", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      data_in  = d;
      inv_in   = inv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = rand128();
      inv_in   = 1'($urandom);
   endtask

   // One full block with out_ready high: returns result, edges from accept
   // to out_valid, and the number of sampled cycles with busy high.
   task automatic runBlock(input logic [127:0] d, input logic inv,
                           output logic [127:0] res, output int lat, output int busyCyc);
      applyStimulus(d, inv);
      lat     = 0;
      busyCyc = busy ? 1 : 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busyCyc++;
      end
      res = data_out;
      @(posedge clk);
      #1;
      if (busy) busyCyc++;
   endtask

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] res, pat, d, exp, held, res1, res16;
      int           lat, bc, lat1, lat16;
      logic         inv, sawValid, sawBusy;

      compared   = 0;
      mismatched = 0;
      buildTables();

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      inv_in    = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;

      // Reset values while reset is held.
      #12;
      checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
      checkOutput("rst_data_out", data_out, 128'd0);
      checkOutput("rst_busy", 128'(busy), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 128'(in_ready), 128'd1);

      // All-zero block: latency N, busy for N+1 sampled cycles.
      runBlock(128'd0, 1'b0, res, lat, bc);
      checkOutput("zero_data_model", res, refSub(128'd0, 1'b0));
      checkOutput("zero_data_const", res, {16{8'h63}});
      checkOutput("zero_latency", 128'(lat), 128'(N_MAIN));
      checkOutput("zero_busy_cycles", 128'(bc), 128'(N_MAIN + 1));

      // 00 10 20 ... F0 forward, then back through the inverse box.
      for (int i = 0; i < 16; i++) pat[127 - 8*i -: 8] = 8'(i * 16);
      runBlock(pat, 1'b0, res, lat, bc);
      checkOutput("pattern_fwd", res, refSub(pat, 1'b0));
      runBlock(res, 1'b1, res, lat, bc);
      checkOutput("pattern_roundtrip", res, pat);

      // Known S-box points placed in bytes 0 and 1.
      d = rand128();
      d[127:112] = 16'h53FF;
      runBlock(d, 1'b0, res, lat, bc);
      checkOutput("spot_S53", 128'(res[127:120]), 128'(8'hED));
      checkOutput("spot_SFF", 128'(res[119:112]), 128'(8'h16));
      d = rand128();
      d[127:112] = 16'h63ED;
      runBlock(d, 1'b1, res, lat, bc);
      checkOutput("spot_InvS63", 128'(res[127:120]), 128'(8'h00));
      checkOutput("spot_InvSED", 128'(res[119:112]), 128'(8'h53));

      // Randomised blocks in both modes.
      for (int k = 0; k < 24; k++) begin
         d   = rand128();
         inv = 1'($urandom);
         runBlock(d, inv, res, lat, bc);
         checkOutput("rand_data", res, refSub(d, inv));
         checkOutput("rand_latency", 128'(lat), 128'(N_MAIN));
      end

      // Backpressure: result must sit still in DONE for 10 cycles.
      out_ready = 1'b0;
      d   = rand128();
      exp = refSub(d, 1'b0);
      applyStimulus(d, 1'b0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("bp_latency", 128'(lat), 128'(N_MAIN));
      held = data_out;
      checkOutput("bp_data", held, exp);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
         checkOutput("bp_data_stable", data_out, exp);
         checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_out_valid", 128'(out_valid), 128'd0);
      checkOutput("bp_release_in_ready", 128'(in_ready), 128'd1);

      // Flush at cnt=2 with a coincident in_valid: nothing comes out and
      // the coincident block is not taken.
      applyStimulus(rand128(), 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      data_in  = rand128();
      inv_in   = 1'b0;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_in_ready", 128'(in_ready), 128'd1);
      checkOutput("flush_busy", 128'(busy), 128'd0);
      sawValid = 1'b0;
      sawBusy  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid = 1'b1;
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("flush_no_out_valid", 128'(sawValid), 128'd0);
      checkOutput("flush_no_accept", 128'(sawBusy), 128'd0);
      d = rand128();
      runBlock(d, 1'b1, res, lat, bc);
      checkOutput("after_flush_data", res, refSub(d, 1'b1));
      checkOutput("after_flush_latency", 128'(lat), 128'(N_MAIN));

      // Asynchronous reset between edges in the middle of a block.
      applyStimulus(rand128(), 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", 128'(out_valid), 128'd0);
      checkOutput("async_rst_data_out", data_out, 128'd0);
      checkOutput("async_rst_busy", 128'(busy), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d = rand128();
      runBlock(d, 1'b0, res, lat, bc);
      checkOutput("after_rst_data", res, refSub(d, 1'b0));

      // LANES=1 and LANES=16 builds on 0x0101...01.
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = {16{8'h01}};
      inv_in   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat1  = -1;
      lat16 = -1;
      res1  = '0;
      res16 = '0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (lat1 < 0 && out_valid_1) begin
            lat1 = e;
            res1 = data_out_1;
         end
         if (lat16 < 0 && out_valid_16) begin
            lat16 = e;
            res16 = data_out_16;
         end
         if (lat1 >= 0 && lat16 >= 0) break;
      end
      checkOutput("lanes1_latency", 128'(lat1), 128'd16);
      checkOutput("lanes16_latency", 128'(lat16), 128'd1);
      checkOutput("lanes1_data", res1, {16{8'h7C}});
      checkOutput("lanes16_data", res16, refSub({16{8'h01}}, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
